// File: rtl/pipe_adder_pkg.sv
// Types, defaults and the overflow helper shared by the pipelined adder files.
package pipe_adder_pkg;
`include "adder_defs.vh"

  typedef enum logic {
    MODE_ADD = `ADDER_MODE_ADD,
    MODE_SUB = `ADDER_MODE_SUB
  } mode_e;

  localparam int DEFAULT_WIDTH  = `ADDER_DEFAULT_WIDTH;
  localparam int DEFAULT_STAGES = `ADDER_DEFAULT_STAGES;

  // Signed overflow from the MSBs of the two addends (b already inverted for sub).
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_defs.vh
// Shared mode encodings and default geometry for the pipelined adder.
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH

`define ADDER_MODE_ADD 1'b0
`define ADDER_MODE_SUB 1'b1
`define ADDER_DEFAULT_WIDTH 32
`define ADDER_DEFAULT_STAGES 4

`endif

// File: rtl/adder_stage.sv
// One pipeline slice: ripple-adds operand slice IDX with the incoming carry and
// registers the partial sum, carry and operands behind a valid/ready register.
module adder_stage #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int LO = IDX * SLICE;

  logic [SLICE:0]   c;
  logic [SLICE-1:0] slice_sum;
  logic [WIDTH-1:0] sum_next;

  assign c[0] = in_carry;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    full_adder u_fa (
      .x    (in_a[LO+i]),
      .y    (in_b[LO+i]),
      .cin  (c[i]),
      .sum  (slice_sum[i]),
      .cout (c[i+1])
    );
  end

  always_comb begin
    sum_next = in_sum;
    sum_next[LO +: SLICE] = slice_sum;
  end

  // Load when empty or when the downstream register is taking our contents.
  assign in_ready = !out_valid || out_ready;

  // Operands travel whole; bits already consumed have no loads and trim away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a     <= in_a;
        out_b     <= in_b;
        out_sum   <= sum_next;
        out_carry <= c[SLICE];
      end
    end
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple chains.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with valid/ready flow control; STAGES slices of
// WIDTH/STAGES bits each, carry registered between slices.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and data until then. Ready ripples back combinationally
  // from out_ready; valid only moves forward through registers.
  logic             vld        [STAGES+1];
  logic             rdy        [STAGES+1];
  logic [WIDTH-1:0] a_pipe     [STAGES+1];
  logic [WIDTH-1:0] b_pipe     [STAGES+1];
  logic [WIDTH-1:0] sum_pipe   [STAGES+1];
  logic             carry_pipe [STAGES+1];
  logic             is_sub;

  assign is_sub = (mode_e'(sub) == MODE_SUB);

  assign vld[0]        = in_valid;
  assign in_ready      = rdy[0];
  assign rdy[STAGES]   = out_ready;
  assign a_pipe[0]     = a;
  assign b_pipe[0]     = is_sub ? ~b : b;
  assign sum_pipe[0]   = '0;
  assign carry_pipe[0] = is_sub ? 1'b1 : ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_a      (a_pipe[k]),
      .in_b      (b_pipe[k]),
      .in_sum    (sum_pipe[k]),
      .in_carry  (carry_pipe[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_a     (a_pipe[k+1]),
      .out_b     (b_pipe[k+1]),
      .out_sum   (sum_pipe[k+1]),
      .out_carry (carry_pipe[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign s         = sum_pipe[STAGES];
  assign co        = carry_pipe[STAGES];
  assign ovf       = signed_ovf(a_pipe[STAGES][WIDTH-1], b_pipe[STAGES][WIDTH-1],
                                sum_pipe[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and model-checked bench for pipe_adder (32/4 plus 8/1 and 8/8 builds).
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [31:0] a, b, s;

  logic       iv8, ci8, sub8, or8;
  logic [7:0] a8, b8;
  logic       rdy_1, ov_1, co_1, ovf_1;
  logic       rdy_8, ov_8, co_8, ovf_8;
  logic [7:0] s_1, s_8;

  int n_checks;
  int n_fails;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut_w8_s1 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy_1),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8),
    .out_valid(ov_1), .out_ready(or8), .s(s_1), .co(co_1), .ovf(ovf_1)
  );

  pipe_adder #(.WIDTH(8), .STAGES(8)) dut_w8_s8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy_8),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8),
    .out_valid(ov_8), .out_ready(or8), .s(s_8), .co(co_8), .ovf(ovf_8)
  );

  // Reference: {ovf, co, s} from signed/unsigned arithmetic on wide values.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic m);
    logic signed [32:0] wide;
    logic [32:0] u;
    logic carry;
    if (m) begin
      wide  = $signed({x[31], x}) - $signed({y[31], y});
      carry = (x >= y);
    end else begin
      wide  = $signed({x[31], x}) + $signed({y[31], y}) + $signed({32'd0, c});
      u     = {1'b0, x} + {1'b0, y} + {32'd0, c};
      carry = u[32];
    end
    return {wide[32] != wide[31], carry, wide[31:0]};
  endfunction

  // One cycle: drive inputs just after the edge, then report what the next edge transfers.
  task automatic drive_cycle(input logic iv, input logic [31:0] ai, input logic [31:0] bi,
                             input logic ci_i, input logic sub_i, input logic ordy,
                             output logic acc, output logic emit, output logic [33:0] obs);
    @(posedge clk);
    #1;
    in_valid  = iv;
    a         = ai;
    b         = bi;
    ci        = ci_i;
    sub       = sub_i;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    obs  = {ovf, co, s};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (s !== 32'd0) begin n_fails++; $display("FAIL reset_s: got %h expected 00000000", s); end
    n_checks++; if (co !== 1'b0) begin n_fails++; $display("FAIL reset_co: got %b expected 0", co); end
    n_checks++; if (ovf !== 1'b0) begin n_fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if ({ov_1, ov_8} !== 2'b00) begin n_fails++; $display("FAIL reset_small_valid: got %b expected 00", {ov_1, ov_8}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if ({rdy_1, rdy_8} !== 2'b11) begin n_fails++; $display("FAIL reset_small_ready: got %b expected 11", {rdy_1, rdy_8}); end
  endtask

  task automatic test_directed();
    logic [31:0] va [8] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h12345678,
                            32'h00000010, 32'h80000000, 32'h000000FF, 32'hFFFFFFFE};
    logic [31:0] vb [8] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h0F0F0F0F,
                            32'h00000003, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [33:0] ve [8] = '{{1'b0, 1'b1, 32'h00000000}, {1'b1, 1'b0, 32'h80000000},
                            {1'b0, 1'b0, 32'hFFFFFFFE}, {1'b0, 1'b0, 32'h21436588},
                            {1'b0, 1'b1, 32'h0000000D}, {1'b1, 1'b1, 32'h7FFFFFFF},
                            {1'b0, 1'b0, 32'h00000100}, {1'b0, 1'b1, 32'hFFFFFFFD}};
    logic acc, emit;
    logic [33:0] obs, res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1, acc, emit, obs);
      n_checks++; if (acc !== 1'b1) begin n_fails++; $display("FAIL directed%0d_accept: got %b expected 1", i, acc); end
      lat = 0;
      res = '0;
      for (int t = 1; t <= 10 && lat == 0; t++) begin
        drive_cycle(1'b0, va[i], vb[i], vc[i], vs[i], 1'b1, acc, emit, obs);
        if (emit) begin lat = t; res = obs; end
      end
      n_checks++; if (lat != 4) begin n_fails++; $display("FAIL directed%0d_latency: got %0d expected 4", i, lat); end
      n_checks++; if (res[31:0] !== ve[i][31:0]) begin n_fails++; $display("FAIL directed%0d_s: got %h expected %h", i, res[31:0], ve[i][31:0]); end
      n_checks++; if (res[32] !== ve[i][32]) begin n_fails++; $display("FAIL directed%0d_co: got %b expected %b", i, res[32], ve[i][32]); end
      n_checks++; if (res[33] !== ve[i][33]) begin n_fails++; $display("FAIL directed%0d_ovf: got %b expected %b", i, res[33], ve[i][33]); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit;
    logic [33:0] obs, exp;
    logic [31:0] xa, xb;
    logic xc, xs, iv;
    int sent, got;
    bit rdy_ok;
    sent = 0; got = 0; rdy_ok = 1;
    exp_q.delete();
    xa = $urandom; xb = $urandom; xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      iv = (sent < 16);
      drive_cycle(iv, xa, xb, xc, xs, 1'b1, acc, emit, obs);
      if (iv && !acc) rdy_ok = 0;
      if (emit) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL b2b_unexpected: got %h expected no result", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin n_fails++; $display("FAIL b2b_result%0d: got %h expected %h", got, obs, exp); end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(xa, xb, xc, xs));
        sent++;
        xa = $urandom; xb = $urandom; xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
      end
    end
    n_checks++; if (got != 16) begin n_fails++; $display("FAIL b2b_count: got %0d expected 16", got); end
    n_checks++; if (rdy_ok != 1) begin n_fails++; $display("FAIL b2b_in_ready: got dropped expected constant 1"); end
  endtask

  task automatic test_stall();
    logic acc, emit;
    logic [33:0] obs, exp, held;
    logic [31:0] xa, xb;
    logic xc, xs, iv, last_rdy, seen;
    int sent, got, acc_cnt;
    bit stable_ok;
    sent = 0; got = 0; acc_cnt = 0; stable_ok = 1; seen = 0; held = '0; last_rdy = 1'b1;
    exp_q.delete();
    xa = $urandom; xb = $urandom; xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive_cycle(1'b1, xa, xb, xc, xs, 1'b0, acc, emit, obs);
      last_rdy = in_ready;
      if (out_valid) begin
        if (!seen) begin held = obs; seen = 1'b1; end
        else if (obs !== held) stable_ok = 0;
      end
      if (acc) begin
        acc_cnt++;
        exp_q.push_back(model(xa, xb, xc, xs));
        sent++;
        xa = $urandom; xb = $urandom; xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
      end
    end
    n_checks++; if (acc_cnt != 4) begin n_fails++; $display("FAIL stall_accepts: got %0d expected 4", acc_cnt); end
    n_checks++; if (last_rdy !== 1'b0) begin n_fails++; $display("FAIL stall_in_ready: got %b expected 0", last_rdy); end
    n_checks++; if (seen !== 1'b1) begin n_fails++; $display("FAIL stall_out_valid: got %b expected 1", seen); end
    n_checks++; if (stable_ok != 1) begin n_fails++; $display("FAIL stall_hold: got changing output expected held %h", held); end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      iv = (sent < 8);
      drive_cycle(iv, xa, xb, xc, xs, 1'b1, acc, emit, obs);
      if (emit) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL stall_unexpected: got %h expected no result", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin n_fails++; $display("FAIL stall_result%0d: got %h expected %h", got, obs, exp); end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(xa, xb, xc, xs));
        sent++;
        xa = $urandom; xb = $urandom; xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
      end
    end
    n_checks++; if (got != 8) begin n_fails++; $display("FAIL stall_count: got %0d expected 8", got); end
  endtask

  task automatic test_reset_mid();
    logic acc, emit;
    logic [33:0] obs;
    logic [31:0] ops [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    int early, leaked, acc_cnt;
    logic rdy_after;
    early = 0; leaked = 0; acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, ops[i], 32'h01010101, 1'b0, 1'b0, 1'b1, acc, emit, obs);
      if (acc) acc_cnt++;
      if (emit) early++;
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc, emit, obs);
    if (emit) early++;
    n_checks++; if (acc_cnt != 3) begin n_fails++; $display("FAIL rstmid_accepts: got %0d expected 3", acc_cnt); end
    n_checks++; if (early != 0) begin n_fails++; $display("FAIL rstmid_early: got %0d results expected 0", early); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (s !== 32'd0) begin n_fails++; $display("FAIL rstmid_s: got %h expected 00000000", s); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc, emit, obs);
    rdy_after = in_ready;
    if (out_valid) leaked++;
    for (int t = 0; t < 12; t++) begin
      drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc, emit, obs);
      if (out_valid) leaked++;
    end
    n_checks++; if (rdy_after !== 1'b1) begin n_fails++; $display("FAIL rstmid_in_ready: got %b expected 1", rdy_after); end
    n_checks++; if (leaked != 0) begin n_fails++; $display("FAIL rstmid_leak: got %0d results expected 0", leaked); end
  endtask

  task automatic test_small();
    int lat1, lat8;
    logic [9:0] r1, r8;
    lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
    @(posedge clk);
    #1;
    iv8 = 1'b1; a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      if (ov_1 && lat1 == 0) begin lat1 = t; r1 = {ovf_1, co_1, s_1}; end
      if (ov_8 && lat8 == 0) begin lat8 = t; r8 = {ovf_8, co_8, s_8}; end
      @(posedge clk);
      #1;
    end
    n_checks++; if (lat1 != 1) begin n_fails++; $display("FAIL w8s1_latency: got %0d expected 1", lat1); end
    n_checks++; if (r1[7:0] !== 8'h00) begin n_fails++; $display("FAIL w8s1_s: got %h expected 00", r1[7:0]); end
    n_checks++; if (r1[8] !== 1'b1) begin n_fails++; $display("FAIL w8s1_co: got %b expected 1", r1[8]); end
    n_checks++; if (r1[9] !== 1'b1) begin n_fails++; $display("FAIL w8s1_ovf: got %b expected 1", r1[9]); end
    n_checks++; if (lat8 != 8) begin n_fails++; $display("FAIL w8s8_latency: got %0d expected 8", lat8); end
    n_checks++; if (r8[7:0] !== 8'h00) begin n_fails++; $display("FAIL w8s8_s: got %h expected 00", r8[7:0]); end
    n_checks++; if (r8[8] !== 1'b1) begin n_fails++; $display("FAIL w8s8_co: got %b expected 1", r8[8]); end
    n_checks++; if (r8[9] !== 1'b1) begin n_fails++; $display("FAIL w8s8_ovf: got %b expected 1", r8[9]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
